data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Synthesizable multi-channel memory responder: the memory end of the valid/ready read/write channel protocol driven by the gpu's data and program memory controllers.
- Holds a word-addressed storage array and serves NUM_CHANNELS independent channels, each with a fixed per-transaction latency.
- Replaces the behavioural bench memory in system-level sims and FPGA builds; a host init port preloads program and data before start.

Parameters:
- ADDR_BITS, 8, address width; array depth is 2**ADDR_BITS words.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 4, number of independent request channels.
- DATA_READ_NUM, 1, words returned per read (program memory instance uses 4).
- READ_LATENCY, 2, cycles from read acceptance to read ready; minimum 1.
- WRITE_LATENCY, 2, cycles from write acceptance to write ready; minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- init_write_enable  in  1  host preload strobe.
- init_address  in  ADDR_BITS  host preload address.
- init_data  in  DATA_BITS  host preload word.
- mem_read_valid  in  NUM_CHANNELS  per-channel read request.
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  read address.
- mem_read_ready  out  NUM_CHANNELS  read response strobe.
- mem_read_data  out  DATA_READ_NUM*DATA_BITS x NUM_CHANNELS (unpacked)  read data; word k at bits [k*DATA_BITS +: DATA_BITS].
- mem_write_valid  in  NUM_CHANNELS  per-channel write request.
- mem_write_address  in  ADDR_BITS x NUM_CHANNELS (unpacked)  write address.
- mem_write_data  in  DATA_BITS x NUM_CHANNELS (unpacked)  write data.
- mem_write_ready  out  NUM_CHANNELS  write completion strobe.

Behaviour:
- Reset (async, active-high):
  - All channels go to IDLE; all mem_read_ready/mem_write_ready = 0; all mem_read_data = 0; latency counters = 0.
  - Array contents are not reset. Reset mid-transaction drops the transaction with no array update.
- Per-channel FSM: IDLE, READ_WAIT, WRITE_WAIT, DRAIN.
- IDLE:
  - At an edge with read valid high: capture address, load counter with READ_LATENCY, go to READ_WAIT.
  - Else at an edge with write valid high: capture address and data, load counter with WRITE_LATENCY, go to WRITE_WAIT.
  - Read has priority when both are high; the write stays pending until a later IDLE.
- READ_WAIT / WRITE_WAIT:
  - Counter decrements each edge. Inputs are ignored.
  - On the edge where the counter reaches 0, ready is driven high for exactly one cycle and the FSM goes to DRAIN.
  - Latency: a request accepted at edge N gives ready high in the cycle following edge N+L-1, so L=1 means ready is visible the cycle right after acceptance.
- Read completion:
  - mem_read_data is registered at the ready edge: word k = array[(addr+k) mod 2**ADDR_BITS], so the address wraps at the top.
  - mem_read_data holds its value until the next read completes on that channel.
- Write completion: array[addr] <= captured data at the ready edge.
- DRAIN:
  - Stays until both valids for the channel are sampled low, then returns to IDLE.
  - This guarantees no re-acceptance, because the controller drops valid one cycle after seeing ready.
- Same-edge conflicts:
  - A read completing at the same edge as a write to the same word returns the old data.
  - Multiple write completions to the same word at one edge: the highest channel index wins.
  - init_write_enable overrides all channel writes to the same word at that edge.
  - init writes are allowed at any time, take effect at the edge, and produce no handshake.
- Channels are fully independent; there is no arbitration stall between channels.

Decomposition:
- Package mem_responder_pkg:
  - Channel state enum (IDLE, READ_WAIT, WRITE_WAIT, DRAIN), 2 bits.
  - Latency counter width constant derived from max(READ_LATENCY, WRITE_LATENCY).
- One sub-module, mem_responder_channel:
  - Contains the FSM, counter, captured address/data and ready strobes.
  - Outputs a write-commit request (enable, address, data) and a read-sample request to the top.
- The top owns the array, the prioritized write-commit mux (init > highest channel), the wrapped multi-word read, and a generate loop of channels.

Test Plan:
- Reset with READ_LATENCY=2: preload array[0x10]=0x5A via init, then raise ch0 read valid with address 0x10 at edge N -> ready high only in cycle after edge N+1, data=0x5A; ready low for all other cycles; no second ready while valid held one extra cycle.
- Write from ch1 to 0x20 with data 0x33 (WRITE_LATENCY=2), then read 0x20 from ch2 -> write ready one cycle pulse; read returns 0x33.
- DATA_READ_NUM=4, preload 0xFE..0x01 with values 1,2,3,4 -> read address 0xFE returns words {1,2,3,4} (wraps to 0x00,0x01), word 0 at LSBs.
- All 4 channels read different addresses at the same edge -> all four ready pulses fire in the same cycle, each with the correct data.
- ch0 and ch3 write 0x11/0x99 to address 0x40 completing the same edge -> array[0x40]=0x99. Repeat with init writing 0x77 at that edge -> 0x77.
- Assert reset while ch0 is in WRITE_WAIT -> ready never pulses, array word unchanged, outputs 0. After release, a new request completes normally.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_pkg : shared types for the multi-channel mem responder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_DRAIN      = 2'd3
  } chan_state_t;

  // Counter only ever holds latency-1, so clog2 of the larger latency is enough.
  function automatic int cnt_bits(input int read_lat, input int write_lat);
    int m;
    m = (read_lat > write_lat) ? read_lat : write_lat;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_channel : per-channel handshake FSM and latency timer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_responder_channel
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 read_ready,
  output logic                 write_ready,
  output logic                 commit_en,
  output logic [ADDR_BITS-1:0] commit_address,
  output logic [DATA_BITS-1:0] commit_data,
  output logic                 sample_en,
  output logic [ADDR_BITS-1:0] sample_address
);

  localparam int CW = cnt_bits(READ_LATENCY, WRITE_LATENCY);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  chan_state_t          state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [ADDR_BITS-1:0] addr_q, addr_next;
  logic [DATA_BITS-1:0] data_q, data_next;
  logic                 rd_done, wr_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      read_ready  <= 1'b0;
      write_ready <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      addr_q      <= addr_next;
      data_q      <= data_next;
      read_ready  <= rd_done;
      write_ready <= wr_done;
    end
  end

  // Completion is decided one edge early so ready is visible L-1 edges after
  // acceptance; a latency of 1 completes on the accepting edge itself.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    addr_next      = addr_q;
    data_next      = data_q;
    rd_done        = 1'b0;
    wr_done        = 1'b0;
    commit_address = addr_q;
    commit_data    = data_q;
    sample_address = addr_q;
    case (state)
      ST_IDLE: begin
        if (read_valid) begin
          addr_next      = read_address;
          sample_address = read_address;
          if (READ_LATENCY == 1) begin
            rd_done    = 1'b1;
            state_next = ST_DRAIN;
          end else begin
            cnt_next   = RD_LOAD;
            state_next = ST_READ_WAIT;
          end
        end else if (write_valid) begin
          addr_next      = write_address;
          data_next      = write_data;
          commit_address = write_address;
          commit_data    = write_data;
          if (WRITE_LATENCY == 1) begin
            wr_done    = 1'b1;
            state_next = ST_DRAIN;
          end else begin
            cnt_next   = WR_LOAD;
            state_next = ST_WRITE_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        cnt_next = cnt - ONE;
        if (cnt == ONE) begin
          rd_done    = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_WRITE_WAIT: begin
        cnt_next = cnt - ONE;
        if (cnt == ONE) begin
          wr_done    = 1'b1;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!read_valid && !write_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign commit_en = wr_done;
  assign sample_en = rd_done;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder : word array serving independent valid/ready chans |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int DATA_READ_NUM = 1,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               init_write_enable,
  input  logic [ADDR_BITS-1:0]               init_address,
  input  logic [DATA_BITS-1:0]               init_data,
  input  logic [NUM_CHANNELS-1:0]            mem_read_valid,
  input  logic [ADDR_BITS-1:0]               mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]            mem_read_ready,
  output logic [DATA_READ_NUM*DATA_BITS-1:0] mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]            mem_write_valid,
  input  logic [ADDR_BITS-1:0]               mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]               mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [NUM_CHANNELS-1:0] commit_en;
  logic [ADDR_BITS-1:0]    commit_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    commit_data    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] sample_en;
  logic [ADDR_BITS-1:0]    sample_address [NUM_CHANNELS];

  // Later assignments win: ascending channel order, then the host preload.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (commit_en[c]) mem[commit_address[c]] <= commit_data[c];
    end
    if (init_write_enable) mem[init_address] <= init_data;
  end

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [DATA_READ_NUM*DATA_BITS-1:0] word_bus;
      logic [DATA_READ_NUM*DATA_BITS-1:0] data_q;

      mem_responder_channel #(
        .ADDR_BITS    (ADDR_BITS),
        .DATA_BITS    (DATA_BITS),
        .READ_LATENCY (READ_LATENCY),
        .WRITE_LATENCY(WRITE_LATENCY)
      ) u_chan (
        .clk           (clk),
        .reset         (reset),
        .read_valid    (mem_read_valid[c]),
        .read_address  (mem_read_address[c]),
        .write_valid   (mem_write_valid[c]),
        .write_address (mem_write_address[c]),
        .write_data    (mem_write_data[c]),
        .read_ready    (mem_read_ready[c]),
        .write_ready   (mem_write_ready[c]),
        .commit_en     (commit_en[c]),
        .commit_address(commit_address[c]),
        .commit_data   (commit_data[c]),
        .sample_en     (sample_en[c]),
        .sample_address(sample_address[c])
      );

      // Address arithmetic is ADDR_BITS wide so multi-word reads wrap at the top.
      always_comb begin
        word_bus = '0;
        for (int k = 0; k < DATA_READ_NUM; k++) begin
          word_bus[k*DATA_BITS +: DATA_BITS] = mem[sample_address[c] + ADDR_BITS'(k)];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else if (sample_en[c]) data_q <= word_bus;
      end

      assign mem_read_data[c] = data_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_responder : directed scoreboard bench for the responder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_data_mem_responder;

  localparam int NC = 4;
  localparam int RL = 2;
  localparam int WL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init_we = 1'b0;
  logic [7:0]    init_addr = '0;
  logic [7:0]    init_data = '0;
  logic [NC-1:0] rv = '0;
  logic [NC-1:0] wv = '0;
  logic [7:0]    ra [NC];
  logic [7:0]    wa [NC];
  logic [7:0]    wd [NC];
  logic [NC-1:0] rr;
  logic [NC-1:0] wr;
  logic [31:0]   rd [NC];

  data_mem_responder #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(NC),
    .DATA_READ_NUM(4), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .init_write_enable(init_we),
    .init_address     (init_addr),
    .init_data        (init_data),
    .mem_read_valid   (rv),
    .mem_read_address (ra),
    .mem_read_ready   (rr),
    .mem_read_data    (rd),
    .mem_write_valid  (wv),
    .mem_write_address(wa),
    .mem_write_data   (wd),
    .mem_write_ready  (wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t    rq [NC][$];
  int         wq [NC][$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] model [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    logic [31:0] r;
    logic [7:0]  ak;
    for (int k = 0; k < 4; k++) begin
      ak = a + 8'(k);
      r[k*8 +: 8] = model[ak];
    end
    return r;
  endfunction

  // Monitor: every ready pulse must match the head of its channel queue.
  always @(negedge clk) begin
    rd_exp_t e;
    int      due;
    if (!reset) begin
      for (int c = 0; c < NC; c++) begin
        if (rr[c]) begin
          if (rq[c].size() == 0) chk($sformatf("rd_spurious_ch%0d", c), 32'd1, 32'd0);
          else begin
            e = rq[c].pop_front();
            chk($sformatf("rd_cycle_ch%0d", c), cyc, e.due);
            chk($sformatf("rd_data_ch%0d", c), rd[c], e.data);
          end
        end
        if (wr[c]) begin
          if (wq[c].size() == 0) chk($sformatf("wr_spurious_ch%0d", c), 32'd1, 32'd0);
          else begin
            due = wq[c].pop_front();
            chk($sformatf("wr_cycle_ch%0d", c), cyc, due);
          end
        end
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d; model[a] = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic rd_txn(input int ch, input logic [7:0] a);
    rd_exp_t e;
    bit      seen;
    seen = 1'b0;
    @(posedge clk); #1;
    rv[ch] = 1'b1; ra[ch] = a;
    e.data = exp_rd(a); e.due = cyc + RL;
    rq[ch].push_back(e);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = rr[ch];
    end
    if (!seen) chk($sformatf("rd_timeout_ch%0d", ch), 32'd0, 32'd1);
    // Controller behaviour: drop valid one cycle after seeing ready.
    @(posedge clk); #1;
    rv[ch] = 1'b0;
  endtask

  task automatic wr_txn(input int ch, input logic [7:0] a, input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    wv[ch] = 1'b1; wa[ch] = a; wd[ch] = d;
    wq[ch].push_back(cyc + WL);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = wr[ch];
    end
    if (!seen) chk($sformatf("wr_timeout_ch%0d", ch), 32'd0, 32'd1);
    @(posedge clk); #1;
    wv[ch] = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_ready"}, {28'd0, rr}, 32'd0);
    chk({tag, "_wr_ready"}, {28'd0, wr}, 32'd0);
    for (int c = 0; c < NC; c++) chk($sformatf("%s_rd_data_ch%0d", tag, c), rd[c], 32'd0);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      ra[c] = '0; wa[c] = '0; wd[c] = '0;
    end
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int a = 0; a < 256; a++) preload(8'(a), 8'(a) ^ 8'hA5);

    // Basic read with latency 2 and valid held an extra cycle.
    preload(8'h10, 8'h5A);
    rd_txn(0, 8'h10);
    chk("read_5a", {24'd0, rd[0][7:0]}, 32'h5A);

    // Write on ch1, read back on ch2.
    wr_txn(1, 8'h20, 8'h33);
    model[8'h20] = 8'h33;
    rd_txn(2, 8'h20);
    chk("write_readback", {24'd0, rd[2][7:0]}, 32'h33);

    // Four-word read wrapping past the top of the array.
    preload(8'hFE, 8'h01);
    preload(8'hFF, 8'h02);
    preload(8'h00, 8'h03);
    preload(8'h01, 8'h04);
    rd_txn(0, 8'hFE);
    chk("wrap_read", rd[0], 32'h04030201);

    // All channels reading in the same cycle.
    fork
      rd_txn(0, 8'h30);
      rd_txn(1, 8'h50);
      rd_txn(2, 8'h70);
      rd_txn(3, 8'h90);
    join
    chk("par_ch3", {24'd0, rd[3][7:0]}, 32'h90 ^ 32'hA5);

    // Same-word write completions: highest channel wins.
    fork
      wr_txn(0, 8'h40, 8'h11);
      wr_txn(3, 8'h40, 8'h99);
    join
    model[8'h40] = 8'h99;
    rd_txn(1, 8'h40);
    chk("conflict_ch3", {24'd0, rd[1][7:0]}, 32'h99);

    // Host preload on the completion edge beats both channels.
    fork
      wr_txn(0, 8'h40, 8'h11);
      wr_txn(3, 8'h40, 8'h99);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        init_we = 1'b1; init_addr = 8'h40; init_data = 8'h77;
        @(posedge clk); #1;
        init_we = 1'b0;
      end
    join
    model[8'h40] = 8'h77;
    rd_txn(1, 8'h40);
    chk("conflict_init", {24'd0, rd[1][7:0]}, 32'h77);

    // Reset while ch0 is waiting on a write: transaction must vanish.
    @(posedge clk); #1;
    wv[0] = 1'b1; wa[0] = 8'h60; wd[0] = 8'hEE;
    @(posedge clk); #1;
    reset = 1'b1; wv[0] = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd_txn(0, 8'h60);
    chk("reset_no_write", {24'd0, rd[0][7:0]}, 32'h60 ^ 32'hA5);
    wr_txn(0, 8'h61, 8'hAB);
    model[8'h61] = 8'hAB;
    rd_txn(0, 8'h60);
    chk("post_reset_write", {16'd0, rd[0][15:0]}, 32'hABC5);

    for (int i = 0; i < 20; i++) @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rd_pending_ch%0d", c), rq[c].size(), 32'd0);
      chk($sformatf("wr_pending_ch%0d", c), wq[c].size(), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
